// File: rtl/alu_seq_nb.sv
// alu_seq_nb: registered, handshaked N-bit ALU with N/Z/C/V flags.
// Ops: ADD SUB AND OR XOR SHL SHR, plus an iterative shift-add MUL when
// the ALU_MUL_EN macro is defined. Without ALU_MUL_EN, op 111 completes in
// one EXEC cycle with result 0, Z=1 and err=1.
// Flow: IDLE -> (EXEC | MUL) -> DONE -> IDLE. Outputs hold in DONE until
// out_ready; the return to IDLE costs one bubble cycle.
module alu_seq_nb #(
  parameter int N   = 8,
  parameter int SHW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t       state, nstate;
  logic [N-1:0] a_q, b_q;
  logic [2:0]   op_q;

  // single-cycle datapath outputs
  logic [N-1:0]   ex_res;
  logic           ex_c, ex_v, ex_err;
  logic [N:0]     wide;
  logic [SHW-1:0] sh;
  logic           sh_ok;

`ifdef ALU_MUL_EN
  // multiplier: {mul_hi, mul_lo} is the running product, mul_lo starts as b
  logic [N-1:0]   mul_hi, mul_lo;
  logic [N:0]     mul_sum;
  logic [N-1:0]   mul_lo_nx;
  logic [SHW-1:0] cnt;
  logic           mul_last;

  // one partial-product add per cycle, then shift the pair right by one
  always_comb begin
    mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, a_q} : '0);
    mul_lo_nx = {mul_sum[0], mul_lo[N-1:1]};
    mul_last  = (cnt == SHW'(N-1));
  end
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // next-state logic
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: begin
`ifdef ALU_MUL_EN
        if (in_valid) nstate = (op == 3'b111) ? S_MUL : S_EXEC;
`else
        if (in_valid) nstate = S_EXEC;
`endif
      end
      S_EXEC: nstate = S_DONE;
      S_MUL: begin
`ifdef ALU_MUL_EN
        if (mul_last) nstate = S_DONE;
`else
        nstate = S_IDLE;
`endif
      end
      S_DONE: if (out_ready) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // single-cycle op evaluation on the latched operands
  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_err = 1'b0;
    wide   = '0;
    sh     = b_q[SHW-1:0];
    // shift amounts >= N only exist when N is not a power of two
    sh_ok  = ({1'b0, sh} < (SHW+1)'(N));
    case (op_q)
      3'b000: begin
        {ex_c, ex_res} = {1'b0, a_q} + {1'b0, b_q};
        ex_v = (a_q[N-1] == b_q[N-1]) && (ex_res[N-1] != a_q[N-1]);
      end
      3'b001: begin
        // bit N of the widened difference is the borrow
        {ex_c, ex_res} = {1'b0, a_q} - {1'b0, b_q};
        ex_v = (a_q[N-1] ^ b_q[N-1]) & (a_q[N-1] ^ ex_res[N-1]);
      end
      3'b010: ex_res = a_q & b_q;
      3'b011: ex_res = a_q | b_q;
      3'b100: ex_res = a_q ^ b_q;
      3'b101: if (sh_ok) begin
        // the extra top bit catches the last bit shifted out
        wide   = {1'b0, a_q} << sh;
        ex_res = wide[N-1:0];
        ex_c   = wide[N];
      end
      3'b110: if (sh_ok) begin
        wide   = {a_q, 1'b0} >> sh;
        ex_res = wide[N:1];
        ex_c   = wide[0];
      end
      default: ex_err = 1'b1;
    endcase
  end

  // operand capture, multiply iteration and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result    <= '0;
      result_hi <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_MUL_EN
      mul_hi    <= '0;
      mul_lo    <= '0;
      cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          op_q <= op;
`ifdef ALU_MUL_EN
          mul_hi <= '0;
          mul_lo <= b;
          cnt    <= '0;
`endif
        end
        S_EXEC: begin
          result    <= ex_res;
          result_hi <= '0;
          flag_n    <= ex_res[N-1];
          flag_z    <= (ex_res == '0);
          flag_c    <= ex_c;
          flag_v    <= ex_v;
          err       <= ex_err;
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          mul_hi <= mul_sum[N:1];
          mul_lo <= mul_lo_nx;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            result    <= mul_lo_nx;
            result_hi <= mul_sum[N:1];
            flag_n    <= mul_lo_nx[N-1];
            flag_z    <= (mul_lo_nx == '0);
            flag_c    <= 1'b0;
            flag_v    <= (mul_sum[N:1] != '0);
            err       <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
